// File: rtl/riscv_pkg.sv
// Shared integer register-file constants and the write-back request type.
package riscv_pkg;

  localparam int unsigned REG_NUM = 32;
  localparam int unsigned REG_AW  = 5;
  localparam int unsigned XLEN    = 32;

  typedef struct packed {
    logic [REG_AW-1:0] addr;
    logic [XLEN-1:0]   data;
  } wb_req_t;

  // Identity of the most recent write-port winner; reset value reads as LSU.
  typedef enum logic {
    GntLsu = 1'b0,
    GntAlu = 1'b1
  } grant_e;

endpackage

// File: rtl/rf_sb_counter.sv
// Saturating outstanding-write counter for one register; err_o pulses on overflow/underflow.
module rf_sb_counter #(
  parameter int unsigned CntW = 2
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] count_o,
  output logic            full_o,
  output logic            err_o
);

  localparam logic [CntW-1:0] CntMax = '1;

  logic [CntW-1:0] count_q, count_d;
  logic            inc_ok;

  assign full_o  = (count_q == CntMax);
  assign inc_ok  = inc_i && !full_o;
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    err_o   = inc_i && full_o;
    // A simultaneous accepted increment and decrement cancel out.
    case ({inc_ok, dec_i})
      2'b10: count_d = count_q + 1'b1;
      2'b01: begin
        if (count_q == '0) begin
          err_o = 1'b1;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-back controller: ALU/LSU round-robin arbiter, registered write
// stage and per-register outstanding-write scoreboard.
module rf_wb_ctrl
  import riscv_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              alu_wb_valid,
  output logic              alu_wb_ready,
  input  logic [REG_AW-1:0] alu_wb_addr,
  input  logic [XLEN-1:0]   alu_wb_data,
  input  logic              lsu_wb_valid,
  output logic              lsu_wb_ready,
  input  logic [REG_AW-1:0] lsu_wb_addr,
  input  logic [XLEN-1:0]   lsu_wb_data,
  output logic              wr_ch0_en,
  output logic [REG_AW-1:0] wr_ch0_addr,
  output logic [XLEN-1:0]   wr_ch0_data,
  input  logic              sb_set_en,
  input  logic [REG_AW-1:0] sb_set_addr,
  input  logic [REG_AW-1:0] sb_rs1_addr,
  input  logic [REG_AW-1:0] sb_rs2_addr,
  output logic              sb_rs1_busy,
  output logic              sb_rs2_busy,
  output logic              sb_set_full,
  output logic              sb_err
);

  grant_e            last_grant_q, last_grant_d;
  logic              gnt_alu, gnt_lsu;
  wb_req_t           win_req;
  logic              wr_en_q, wr_en_d;
  logic [REG_AW-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;
  logic              err_q, err_d;

  logic [CNT_W-1:0]   cnt [REG_NUM];
  logic [REG_NUM-1:0] full_vec;
  logic [REG_NUM-1:0] err_vec;

  // Round-robin: on contention the requester that did not win last time is granted.
  always_comb begin
    gnt_alu = alu_wb_valid && (!lsu_wb_valid || (last_grant_q == GntLsu));
    gnt_lsu = lsu_wb_valid && (!alu_wb_valid || (last_grant_q == GntAlu));
  end

  assign alu_wb_ready = gnt_alu;
  assign lsu_wb_ready = gnt_lsu;

  always_comb begin
    win_req      = '{addr: alu_wb_addr, data: alu_wb_data};
    last_grant_d = last_grant_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    if (gnt_lsu) begin
      win_req = '{addr: lsu_wb_addr, data: lsu_wb_data};
    end
    if (gnt_alu || gnt_lsu) begin
      last_grant_d = gnt_alu ? GntAlu : GntLsu;
      // x0 writes complete the handshake but never reach the register file.
      wr_en_d      = (win_req.addr != '0);
      wr_addr_d    = win_req.addr;
      wr_data_d    = win_req.data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant_q <= GntLsu;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      err_q        <= err_d;
    end
  end

  assign wr_ch0_en   = wr_en_q;
  assign wr_ch0_addr = wr_addr_q;
  assign wr_ch0_data = wr_data_q;

  assign cnt[0]      = '0;
  assign full_vec[0] = 1'b0;
  assign err_vec[0]  = 1'b0;

  for (genvar i = 1; i < REG_NUM; i++) begin : g_cnt
    rf_sb_counter #(
      .CntW (CNT_W)
    ) u_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc_i   (sb_set_en && (sb_set_addr == REG_AW'(i))),
      .dec_i   (wr_en_q && (wr_addr_q == REG_AW'(i))),
      .count_o (cnt[i]),
      .full_o  (full_vec[i]),
      .err_o   (err_vec[i])
    );
  end

  assign err_d  = err_q | (|err_vec);
  assign sb_err = err_q;

  // No forwarding from the write stage: a register written this cycle still reads busy.
  assign sb_rs1_busy = (cnt[sb_rs1_addr] != '0);
  assign sb_rs2_busy = (cnt[sb_rs2_addr] != '0);
  assign sb_set_full = full_vec[sb_set_addr];

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: reference arbiter/scoreboard model plus a queue of
// expected register-file writes.
module tb_rf_wb_ctrl;

  localparam int CNT_W   = 2;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic        clk;
  logic        reset_n;
  logic        alu_wb_valid, alu_wb_ready;
  logic [4:0]  alu_wb_addr;
  logic [31:0] alu_wb_data;
  logic        lsu_wb_valid, lsu_wb_ready;
  logic [4:0]  lsu_wb_addr;
  logic [31:0] lsu_wb_data;
  logic        wr_ch0_en;
  logic [4:0]  wr_ch0_addr;
  logic [31:0] wr_ch0_data;
  logic        sb_set_en;
  logic [4:0]  sb_set_addr, sb_rs1_addr, sb_rs2_addr;
  logic        sb_rs1_busy, sb_rs2_busy, sb_set_full, sb_err;

  rf_wb_ctrl #(
    .CNT_W (CNT_W)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_ready (alu_wb_ready),
    .alu_wb_addr  (alu_wb_addr),
    .alu_wb_data  (alu_wb_data),
    .lsu_wb_valid (lsu_wb_valid),
    .lsu_wb_ready (lsu_wb_ready),
    .lsu_wb_addr  (lsu_wb_addr),
    .lsu_wb_data  (lsu_wb_data),
    .wr_ch0_en    (wr_ch0_en),
    .wr_ch0_addr  (wr_ch0_addr),
    .wr_ch0_data  (wr_ch0_data),
    .sb_set_en    (sb_set_en),
    .sb_set_addr  (sb_set_addr),
    .sb_rs1_addr  (sb_rs1_addr),
    .sb_rs2_addr  (sb_rs2_addr),
    .sb_rs1_busy  (sb_rs1_busy),
    .sb_rs2_busy  (sb_rs2_busy),
    .sb_set_full  (sb_set_full),
    .sb_err       (sb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  int          cnt_m [32];
  bit          err_m;
  bit          last_alu_m;
  bit          cur_en;
  logic [4:0]  cur_addr;
  logic [31:0] cur_data;
  logic [36:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) cnt_m[i] = 0;
    err_m      = 1'b0;
    last_alu_m = 1'b0;
    cur_en     = 1'b0;
    cur_addr   = '0;
    cur_data   = '0;
    exp_q.delete();
  endtask

  task automatic do_reset(input logic [4:0] r1);
    alu_wb_valid = 1'b0; alu_wb_addr = '0; alu_wb_data = '0;
    lsu_wb_valid = 1'b0; lsu_wb_addr = '0; lsu_wb_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0; sb_rs1_addr = r1; sb_rs2_addr = '0;
    reset_n = 1'b0;
    #1;
    check("rst_wr_en", wr_ch0_en, 0);
    check("rst_wr_addr", wr_ch0_addr, 0);
    check("rst_wr_data", wr_ch0_data, 0);
    check("rst_sb_err", sb_err, 0);
    check("rst_rs1_busy", sb_rs1_busy, 0);
    clear_model();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic step(input logic av, input logic [4:0] aa, input logic [31:0] ad,
                      input logic lv, input logic [4:0] la, input logic [31:0] ld,
                      input logic se, input logic [4:0] sa,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit          ga, gl, inc_ok, dec, nxt_en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [36:0] e;
    alu_wb_valid = av; alu_wb_addr = aa; alu_wb_data = ad;
    lsu_wb_valid = lv; lsu_wb_addr = la; lsu_wb_data = ld;
    sb_set_en = se; sb_set_addr = sa; sb_rs1_addr = r1; sb_rs2_addr = r2;
    #2;
    ga = av && (!lv || !last_alu_m);
    gl = lv && (!av || last_alu_m);
    check("alu_ready", alu_wb_ready, ga);
    check("lsu_ready", lsu_wb_ready, gl);
    check("rs1_busy", sb_rs1_busy, (r1 != 0) && (cnt_m[r1] != 0));
    check("rs2_busy", sb_rs2_busy, (r2 != 0) && (cnt_m[r2] != 0));
    check("set_full", sb_set_full, (sa != 0) && (cnt_m[sa] == CNT_MAX));
    check("sb_err", sb_err, err_m);
    // Scoreboard update at the coming edge, using the write currently on the port.
    inc_ok = se && (sa != 0) && (cnt_m[sa] != CNT_MAX);
    if (se && (sa != 0) && (cnt_m[sa] == CNT_MAX)) err_m = 1'b1;
    dec = cur_en && (cur_addr != 0);
    if (inc_ok && !(dec && (cur_addr == sa))) cnt_m[sa]++;
    if (dec && !(inc_ok && (sa == cur_addr))) begin
      if (cnt_m[cur_addr] == 0) err_m = 1'b1;
      else cnt_m[cur_addr]--;
    end
    nxt_en = 1'b0;
    if (ga || gl) begin
      last_alu_m = ga;
      wa = ga ? aa : la;
      wd = ga ? ad : ld;
      nxt_en = (wa != 0);
      if (nxt_en) exp_q.push_back({wa, wd});
      cur_addr = wa;
      cur_data = wd;
    end
    cur_en = nxt_en;
    @(posedge clk);
    #1;
    check("wr_en", wr_ch0_en, cur_en);
    if (cur_en) begin
      if (exp_q.size() == 0) begin
        check("wr_queue_empty", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", wr_ch0_addr, e[36:32]);
        check("wr_data", wr_ch0_data, e[31:0]);
      end
    end else begin
      check("wr_addr_hold", wr_ch0_addr, cur_addr);
      check("wr_data_hold", wr_ch0_data, cur_data);
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    step(0, 0, 0, 0, 0, 0, 0, 0, r1, r2);
  endtask

  initial begin
    reset_n = 1'b0;
    do_reset(0);

    // Single ALU write to x5, allocated in the same cycle.
    step(1, 5, 32'hDEADBEEF, 0, 0, 0, 1, 5, 5, 0);
    idle(5, 0);
    idle(5, 0);

    // Contention from reset: ALU, LSU, ALU, LSU.
    do_reset(0);
    for (int k = 0; k < 4; k++) begin
      step(1, 1, 32'h1111_1111, 1, 2, 32'h2222_2222, 1, (k % 2 == 0) ? 5'd1 : 5'd2, 1, 2);
    end
    idle(1, 2);
    idle(1, 2);

    // Two allocations to x7 retire only after the second write lands.
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    step(0, 0, 0, 0, 0, 0, 1, 7, 7, 0);
    idle(7, 0);
    step(1, 7, 32'h0000_0007, 0, 0, 0, 0, 0, 7, 0);
    idle(7, 0);
    step(0, 0, 0, 1, 7, 32'h7777_0000, 0, 0, 7, 0);
    idle(7, 0);
    idle(7, 0);

    // Saturation on x9 and overflow error.
    do_reset(0);
    for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    step(0, 0, 0, 0, 0, 0, 0, 9, 0, 9);
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 9);
    step(0, 0, 0, 0, 0, 0, 0, 9, 0, 9);

    // Same-cycle set and retire on x4; then underflow via x3.
    do_reset(0);
    step(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    step(1, 4, 32'h4444_4444, 0, 0, 0, 0, 0, 4, 0);
    step(0, 0, 0, 0, 0, 0, 1, 4, 4, 0);
    idle(4, 0);
    step(1, 3, 32'h3333_3333, 0, 0, 0, 0, 0, 4, 3);
    idle(4, 3);
    idle(4, 3);

    // x0 write from LSU, then reset with a write pending.
    do_reset(0);
    step(0, 0, 0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0);
    idle(0, 0);
    step(0, 0, 0, 0, 0, 0, 1, 6, 6, 0);
    step(1, 6, 32'h6666_6666, 0, 0, 0, 0, 0, 6, 0);
    check("pre_rst_wr_en", wr_ch0_en, 1);
    do_reset(6);
    idle(6, 0);
    step(1, 8, 32'h8888_8888, 1, 10, 32'hAAAA_AAAA, 0, 0, 0, 0);
    step(0, 0, 0, 1, 10, 32'hAAAA_AAAA, 1, 10, 10, 0);
    idle(10, 8);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rf_wb_ctrl.md
Name: rf_wb_ctrl

Overview:
Write-back controller and scoreboard for the integer register file (32 x 32-bit, x0 hard-wired to zero, one write port, two read ports).
- Arbitrates the single write port between the ALU write-back path and the LSU load-return path.
- Drives the register file write channel from a registered output stage.
- Tracks outstanding destination writes per register so the issue stage can stall on RAW/WAW hazards.
- Sits between execute/LSU and the register file, beside decode/issue.

Parameters:
CNT_W, 2, width of each per-register outstanding-write counter (maximum outstanding writes per register = 2^CNT_W-1)

Ports:
clk  input  1  clock
reset_n  input  1  asynchronous active-low reset
alu_wb_valid  input  1  ALU write-back request
alu_wb_ready  output  1  ALU request accepted this cycle
alu_wb_addr  input  5  ALU destination register
alu_wb_data  input  32  ALU result
lsu_wb_valid  input  1  load-return write-back request
lsu_wb_ready  output  1  LSU request accepted this cycle
lsu_wb_addr  input  5  load destination register
lsu_wb_data  input  32  load data
wr_ch0_en  output  1  register file write enable (registered)
wr_ch0_addr  output  5  register file write address (registered)
wr_ch0_data  output  32  register file write data (registered)
sb_set_en  input  1  issue stage allocates a pending write
sb_set_addr  input  5  destination register being allocated
sb_rs1_addr  input  5  source 1 query address
sb_rs2_addr  input  5  source 2 query address
sb_rs1_busy  output  1  rs1 has an outstanding write (combinational)
sb_rs2_busy  output  1  rs2 has an outstanding write (combinational)
sb_set_full  output  1  counter for sb_set_addr is at its maximum; issue must stall (combinational)
sb_err  output  1  sticky underflow/overflow error

Behaviour:
Reset:
- All outputs registered at reset are 0: wr_ch0_en/addr/data, sb_err, all counters, and last_grant (which reads as "LSU").

Arbitration:
- One grant per cycle.
- Only one requester valid: that requester is granted.
- Both valid: round-robin; the requester not granted most recently wins.
- last_grant updates only on a grant.
- *_ready is combinational from the valids and last_grant, and is asserted only for the winner.
- A request holds valid, addr and data stable until ready.
- The arbiter never stalls on downstream; the write port accepts every cycle.

Write stage:
- On a grant, the winner's addr/data are registered into wr_ch0_addr/data.
- wr_ch0_en=1 in the following cycle (latency 1).
- No grant: wr_ch0_en=0 next cycle; addr/data hold their previous values.
- Grant with addr 0: handshake completes, wr_ch0_en stays 0, no scoreboard effect.

Scoreboard:
- One CNT_W-bit counter per register 1..31; register 0 has no counter and always reads not busy.
- Increment: sb_set_en && sb_set_addr!=0 && counter != max.
- Decrement: on the clock edge where wr_ch0_en=1 and wr_ch0_addr!=0. The register file captures the data on the same edge, so from the next cycle the read returns the new value and busy is low.
- Increment and decrement of the same register in the same cycle: counter unchanged.
- Decrement when the counter is 0: counter stays 0 and sb_err is set.
- sb_set_en while the counter is at max: no increment and sb_err is set. Issue must honour sb_set_full to avoid this.
- sb_rsN_busy = (counter[sb_rsN_addr] != 0). There is no forwarding from the in-flight write stage: a register being written this cycle still reads busy.
- sb_err clears only on reset.

Asynchronous reset mid-operation:
- Drops the pending write.
- Clears all counters.
- Requesters must re-present after reset.

Decomposition:
- Shared package (riscv_pkg): REG_NUM=32, REG_AW=5, XLEN=32, and a wb_req_t struct {addr, data}.
- One sub-module, rf_sb_counter: a single saturating up/down counter with inc, dec, count, full and err outputs, instantiated 31 times via generate.
- The 2-way round-robin arbiter and the write stage stay inline.

Test Plan:
1. ALU only: valid, addr 5, data 0xDEADBEEF -> alu_wb_ready=1 same cycle; next cycle wr_ch0_en=1, addr 5, data 0xDEADBEEF; the cycle after, wr_ch0_en=0.
2. Both valid for 4 cycles after reset (ALU addr 1, LSU addr 2) -> grants ALU, LSU, ALU, LSU; wr_ch0_addr sequence 1, 2, 1, 2, each one cycle after its grant.
3. sb_set to addr 7 twice -> rs1=7 reads busy. First write to 7 -> still busy. Second write to 7 -> busy low the cycle after the second wr_ch0_en.
4. CNT_W=2: three sets to addr 9 -> sb_set_full=1. A fourth set -> count stays 3 and sb_err=1.
5. Same cycle: set addr 4 while wr_ch0_en writes addr 4 with count 1 -> count stays 1 and busy remains high. Write to addr 3 with count 0 -> sb_err=1.
6. LSU write to addr 0 -> lsu_wb_ready=1, wr_ch0_en stays 0, rs1=0 never busy. Assert reset_n=0 while a write is pending -> wr_ch0_en=0 and all busy bits cleared immediately.
